// File: rtl/id_ex_hazard_ctrl_pkg.sv
// id_ex_hazard_ctrl_pkg
//   Shared definitions for the load-use hazard controller: register-field
//   width, FSM state encodings, MEM_CTRL bit layout and the output bundle.
//   Optional feature macro used by the top: HAZARD_PERF_CNT_EN.
package id_ex_hazard_ctrl_pkg;

    localparam int unsigned R_WIDTH      = 5;

    // MEM_CTRL field of ID/EX: {MemRead, MemWrite}
    localparam int unsigned MEM_CTRL_W   = 2;
    localparam int unsigned MEM_READ_BIT = 1;

    typedef enum logic {
        HZ_RUN   = 1'b0,
        HZ_STALL = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
    } hz_out_t;

endpackage

// File: rtl/id_ex_hazard_ctrl_if.sv
// id_ex_hazard_ctrl_if
//   Signal bundle between the ID stage / ID-EX register and the hazard
//   controller.
//   master : pipeline side (drives decode/EX fields, consumes enables)
//   slave  : hazard controller
interface id_ex_hazard_ctrl_if;
    import id_ex_hazard_ctrl_pkg::*;

    logic [R_WIDTH-1:0] id_rs_i;
    logic [R_WIDTH-1:0] id_rt_i;
    logic               id_uses_rs_i;
    logic               id_uses_rt_i;
    logic               ex_mem_read_i;
    logic [R_WIDTH-1:0] ex_rt_i;
    logic               branch_taken_i;
    logic               pc_write_o;
    logic               if_id_write_o;
    logic               if_id_flush_o;
    logic               id_ex_bubble_o;

    modport master (
        output id_rs_i, id_rt_i, id_uses_rs_i, id_uses_rt_i,
               ex_mem_read_i, ex_rt_i, branch_taken_i,
        input  pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o
    );

    modport slave (
        input  id_rs_i, id_rt_i, id_uses_rs_i, id_uses_rt_i,
               ex_mem_read_i, ex_rt_i, branch_taken_i,
        output pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o
    );

endinterface

// File: rtl/id_ex_hazard_ctrl_load_use_cmp.sv
// load_use_cmp
//   Combinational load-use compare: flags a hazard when the load in EX
//   writes a non-zero register that the ID instruction actually reads.
//   Ports: ex_mem_read_i, ex_rt_i, id_rs_i, id_rt_i, id_uses_rs_i,
//          id_uses_rt_i -> hazard_o
module load_use_cmp
    import id_ex_hazard_ctrl_pkg::*;
(
    input  logic               ex_mem_read_i,
    input  logic [R_WIDTH-1:0] ex_rt_i,
    input  logic [R_WIDTH-1:0] id_rs_i,
    input  logic [R_WIDTH-1:0] id_rt_i,
    input  logic               id_uses_rs_i,
    input  logic               id_uses_rt_i,
    output logic               hazard_o
);

    logic rs_hit, rt_hit;

    assign rs_hit   = id_uses_rs_i && (id_rs_i == ex_rt_i);
    assign rt_hit   = id_uses_rt_i && (id_rt_i == ex_rt_i);
    // r0 is hardwired zero, a load into it never creates a dependency
    assign hazard_o = ex_mem_read_i && (ex_rt_i != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/id_ex_hazard_ctrl.sv
// id_ex_hazard_ctrl
//   Load-use hazard controller beside the ID stage. Freezes PC and IF/ID and
//   injects LOAD_LAT bubbles into ID/EX per load-use hazard; flushes IF/ID and
//   ID/EX on a taken branch.
//   Ports: clk_i, rst_n_i (sync, active low), hz (slave modport of
//          id_ex_hazard_ctrl_if), stall_cycles_o (HAZARD_PERF_CNT_EN only).
//   Optional feature macro: HAZARD_PERF_CNT_EN (saturating bubble counter).
module id_ex_hazard_ctrl
    import id_ex_hazard_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    id_ex_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles_o
`endif
);

    if (LOAD_LAT < 1 || LOAD_LAT > 15) begin : g_bad_lat
        $error("LOAD_LAT must be within 1..15");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    // first hazard cycle is the current one, so STALL covers LOAD_LAT-1 more
    localparam bit         MULTI    = (LOAD_LAT > 1);
    localparam logic [3:0] CNT_INIT = MULTI ? 4'(LOAD_LAT - 2) : 4'd0;

    hz_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       hazard;
    hz_out_t    out;

    load_use_cmp u_cmp (
        .ex_mem_read_i (hz.ex_mem_read_i),
        .ex_rt_i       (hz.ex_rt_i),
        .id_rs_i       (hz.id_rs_i),
        .id_rt_i       (hz.id_rt_i),
        .id_uses_rs_i  (hz.id_uses_rs_i),
        .id_uses_rt_i  (hz.id_uses_rt_i),
        .hazard_o      (hazard)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= HZ_RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (hz.branch_taken_i) begin
            state_d = HZ_RUN;
            cnt_d   = 4'd0;
        end else if (state_q == HZ_STALL) begin
            if (cnt_q == 4'd0) state_d = HZ_RUN;
            else               cnt_d   = cnt_q - 4'd1;
        end else if (hazard && MULTI) begin
            state_d = HZ_STALL;
            cnt_d   = CNT_INIT;
        end
    end

    // hazard in RUN bubbles in the same cycle (Mealy); STALL ignores ID
    always_comb begin
        out = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0, id_ex_bubble: 1'b0};
        if (!rst_n_i)
            out = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_bubble: 1'b1};
        else if (hz.branch_taken_i)
            out = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1, id_ex_bubble: 1'b1};
        else if (state_q == HZ_STALL || hazard)
            out = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_bubble: 1'b1};
    end

    assign hz.pc_write_o     = out.pc_write;
    assign hz.if_id_write_o  = out.if_id_write;
    assign hz.if_id_flush_o  = out.if_id_flush;
    assign hz.id_ex_bubble_o = out.id_ex_bubble;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] perf_q;

    // counts hazard bubbles only; branch-flush bubbles are excluded
    always_ff @(posedge clk_i) begin
        if (!rst_n_i)
            perf_q <= '0;
        else if (out.id_ex_bubble && !out.if_id_flush && perf_q != '1)
            perf_q <= perf_q + 1'b1;
    end

    assign stall_cycles_o = perf_q;
`endif

endmodule
